writeback_regfile: RTL and testbench



---
 rtl/writeback_regfile.sv | 91 +++++++++
 tb/tb_writeback_regfile.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/writeback_regfile.sv
// Writeback stage: selects the result word, commits it into the 32-entry
// architectural register file and serves two write-first bypassed read ports.
module writeback_regfile #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      ALUResultW,
    input  logic [WIDTH-1:0]      ReadDataW,
    input  logic [WIDTH-1:0]      PCPlus4W,
    input  logic [ADDR_WIDTH-1:0] RdW,
    input  logic                  RegWriteW,
    input  logic                  ResultSrcW,
    input  logic                  WD3SrcW,
    input  logic [ADDR_WIDTH-1:0] A1,
    input  logic [ADDR_WIDTH-1:0] A2,
    output logic [WIDTH-1:0]      RD1,
    output logic [WIDTH-1:0]      RD2,
    output logic [WIDTH-1:0]      ResultW,
    output logic [WIDTH-1:0]      a0
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;
    localparam int A0_IDX   = 10;

    logic [WIDTH-1:0] regs_q [NUM_REGS];
    logic [WIDTH-1:0] regs_d [NUM_REGS];
    logic [WIDTH-1:0] a0_q;
    logic [WIDTH-1:0] a0_d;
    logic             bypass_en;
    logic             wr_en;

    // Reset also masks the write and the bypass for the cycle it is sampled in.
    assign bypass_en = RegWriteW && !rst;
    assign wr_en     = bypass_en && (RdW != '0);

    always_comb begin
        if (WD3SrcW) begin
            ResultW = PCPlus4W;
        end else if (ResultSrcW) begin
            ResultW = ReadDataW;
        end else begin
            ResultW = ALUResultW;
        end
    end

    always_comb begin
        // NOTE: start from the held value so every path assigns regs_d and no latch is inferred.
        regs_d = regs_q;
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_d[i] = '0;
            end
        end else if (wr_en) begin
            regs_d[RdW] = ResultW;
        end
        regs_d[0] = '0;
    end

    // a0 mirrors x10 as it stands after this edge's write.
    assign a0_d = regs_d[A0_IDX];

    always_comb begin
        RD1 = regs_q[A1];
        if (A1 == '0) begin
            RD1 = '0;
        end else if (bypass_en && (RdW == A1)) begin
            RD1 = ResultW;
        end
    end

    always_comb begin
        RD2 = regs_q[A2];
        if (A2 == '0) begin
            RD2 = '0;
        end else if (bypass_en && (RdW == A2)) begin
            RD2 = ResultW;
        end
    end

    // NOTE: the whole file is architecturally cleared on reset, so the memory is reset through regs_d rather than left uninitialised.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
        regs_q <= regs_d;
        a0_q   <= a0_d;
    end

    assign a0 = a0_q;

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed self-checking bench for writeback_regfile: reset, result select,
// bypass, x0, a0 timing and reset in the middle of a write sequence.
module tb_writeback_regfile;

    logic        clk;
    logic        rst;
    logic [31:0] ALUResultW;
    logic [31:0] ReadDataW;
    logic [31:0] PCPlus4W;
    logic [4:0]  RdW;
    logic        RegWriteW;
    logic        ResultSrcW;
    logic        WD3SrcW;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] RD1;
    logic [31:0] RD2;
    logic [31:0] ResultW;
    logic [31:0] a0;

    int pass_cnt  = 0;
    int total_cnt = 0;

    writeback_regfile #(.WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .ALUResultW (ALUResultW),
        .ReadDataW  (ReadDataW),
        .PCPlus4W   (PCPlus4W),
        .RdW        (RdW),
        .RegWriteW  (RegWriteW),
        .ResultSrcW (ResultSrcW),
        .WD3SrcW    (WD3SrcW),
        .A1         (A1),
        .A2         (A2),
        .RD1        (RD1),
        .RD2        (RD2),
        .ResultW    (ResultW),
        .a0         (a0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_write(input logic we, input logic [4:0] rd, input logic [31:0] alu);
        RegWriteW  = we;
        RdW        = rd;
        ALUResultW = alu;
        ResultSrcW = 1'b0;
        WD3SrcW    = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_write(1'b1, 5'd5, 32'hDEADBEEF);
        A1 = 5'd5;
        A2 = 5'd5;
        tick();
        rst = 1'b0;
        drive_write(1'b0, 5'd0, 32'h0);
        #1;
        total_cnt++; if (RD1 !== 32'h0) $display("FAIL reset_x5: got %h expected %h", RD1, 32'h0); else pass_cnt++;
        total_cnt++; if (a0 !== 32'h0) $display("FAIL reset_a0: got %h expected %h", a0, 32'h0); else pass_cnt++;
        for (int i = 0; i < 32; i++) begin
            A1 = 5'(i);
            A2 = 5'(31 - i);
            #1;
            total_cnt++; if (RD1 !== 32'h0) $display("FAIL reset_all_rd1[%0d]: got %h expected %h", i, RD1, 32'h0); else pass_cnt++;
            total_cnt++; if (RD2 !== 32'h0) $display("FAIL reset_all_rd2[%0d]: got %h expected %h", 31 - i, RD2, 32'h0); else pass_cnt++;
        end
    endtask

    task automatic test_select_mux();
        logic [31:0] exp_res [4];
        exp_res[0] = 32'h11;
        exp_res[1] = 32'h22;
        exp_res[2] = 32'h33;
        exp_res[3] = 32'h33;
        ALUResultW = 32'h11;
        ReadDataW  = 32'h22;
        PCPlus4W   = 32'h33;
        RegWriteW  = 1'b1;
        RdW        = 5'd3;
        for (int k = 0; k < 4; k++) begin
            ResultSrcW = k[0];
            WD3SrcW    = k[1];
            #1;
            total_cnt++; if (ResultW !== exp_res[k]) $display("FAIL mux_sel%0d: got %h expected %h", k, ResultW, exp_res[k]); else pass_cnt++;
            tick();
        end
        drive_write(1'b0, 5'd0, 32'h0);
        A1 = 5'd3;
        A2 = 5'd3;
        #1;
        total_cnt++; if (RD1 !== 32'h33) $display("FAIL mux_x3_rd1: got %h expected %h", RD1, 32'h33); else pass_cnt++;
        total_cnt++; if (RD2 !== 32'h33) $display("FAIL mux_x3_rd2: got %h expected %h", RD2, 32'h33); else pass_cnt++;
    endtask

    task automatic test_bypass();
        drive_write(1'b1, 5'd7, 32'hCAFE0001);
        A1 = 5'd7;
        A2 = 5'd7;
        #1;
        total_cnt++; if (RD1 !== 32'hCAFE0001) $display("FAIL bypass_rd1: got %h expected %h", RD1, 32'hCAFE0001); else pass_cnt++;
        total_cnt++; if (RD2 !== 32'hCAFE0001) $display("FAIL bypass_rd2: got %h expected %h", RD2, 32'hCAFE0001); else pass_cnt++;
        tick();
        // Disabled write with live-looking fields must be ignored.
        drive_write(1'b0, 5'd7, 32'h12345678);
        #1;
        total_cnt++; if (RD1 !== 32'hCAFE0001) $display("FAIL stored_rd1: got %h expected %h", RD1, 32'hCAFE0001); else pass_cnt++;
        total_cnt++; if (RD2 !== 32'hCAFE0001) $display("FAIL stored_rd2: got %h expected %h", RD2, 32'hCAFE0001); else pass_cnt++;
        tick();
        A2 = 5'd3;
        #1;
        total_cnt++; if (RD1 !== 32'hCAFE0001) $display("FAIL no_we_write_rd1: got %h expected %h", RD1, 32'hCAFE0001); else pass_cnt++;
        total_cnt++; if (RD2 !== 32'h33) $display("FAIL split_ports_rd2: got %h expected %h", RD2, 32'h33); else pass_cnt++;
    endtask

    task automatic test_x0();
        drive_write(1'b1, 5'd0, 32'hFFFFFFFF);
        A1 = 5'd0;
        A2 = 5'd0;
        #1;
        total_cnt++; if (ResultW !== 32'hFFFFFFFF) $display("FAIL x0_result: got %h expected %h", ResultW, 32'hFFFFFFFF); else pass_cnt++;
        total_cnt++; if (RD1 !== 32'h0) $display("FAIL x0_bypass_rd1: got %h expected %h", RD1, 32'h0); else pass_cnt++;
        total_cnt++; if (RD2 !== 32'h0) $display("FAIL x0_bypass_rd2: got %h expected %h", RD2, 32'h0); else pass_cnt++;
        tick();
        drive_write(1'b0, 5'd0, 32'h0);
        #1;
        total_cnt++; if (RD1 !== 32'h0) $display("FAIL x0_stored_rd1: got %h expected %h", RD1, 32'h0); else pass_cnt++;
    endtask

    task automatic test_a0_timing();
        drive_write(1'b1, 5'd10, 32'h0000002A);
        #1;
        total_cnt++; if (a0 !== 32'h0) $display("FAIL a0_before_edge: got %h expected %h", a0, 32'h0); else pass_cnt++;
        tick();
        total_cnt++; if (a0 !== 32'h2A) $display("FAIL a0_after_edge: got %h expected %h", a0, 32'h2A); else pass_cnt++;
        drive_write(1'b0, 5'd10, 32'h00000055);
        tick();
        A1 = 5'd10;
        #1;
        total_cnt++; if (a0 !== 32'h2A) $display("FAIL a0_hold: got %h expected %h", a0, 32'h2A); else pass_cnt++;
        total_cnt++; if (RD1 !== 32'h2A) $display("FAIL x10_hold: got %h expected %h", RD1, 32'h2A); else pass_cnt++;
    endtask

    task automatic test_mid_reset();
        drive_write(1'b1, 5'd1, 32'h1);
        tick();
        drive_write(1'b1, 5'd2, 32'h2);
        tick();
        rst = 1'b1;
        drive_write(1'b1, 5'd3, 32'h3);
        A1 = 5'd3;
        #1;
        // Bypass is suppressed under reset, so storage (0x33) shows through.
        total_cnt++; if (RD1 !== 32'h33) $display("FAIL rst_no_bypass: got %h expected %h", RD1, 32'h33); else pass_cnt++;
        tick();
        rst = 1'b0;
        drive_write(1'b0, 5'd0, 32'h0);
        A1 = 5'd1;
        A2 = 5'd2;
        #1;
        total_cnt++; if (RD1 !== 32'h0) $display("FAIL mid_rst_x1: got %h expected %h", RD1, 32'h0); else pass_cnt++;
        total_cnt++; if (RD2 !== 32'h0) $display("FAIL mid_rst_x2: got %h expected %h", RD2, 32'h0); else pass_cnt++;
        total_cnt++; if (a0 !== 32'h0) $display("FAIL mid_rst_a0: got %h expected %h", a0, 32'h0); else pass_cnt++;
        A1 = 5'd3;
        A2 = 5'd10;
        #1;
        total_cnt++; if (RD1 !== 32'h0) $display("FAIL mid_rst_x3: got %h expected %h", RD1, 32'h0); else pass_cnt++;
        total_cnt++; if (RD2 !== 32'h0) $display("FAIL mid_rst_x10: got %h expected %h", RD2, 32'h0); else pass_cnt++;
        drive_write(1'b1, 5'd1, 32'h9);
        tick();
        drive_write(1'b0, 5'd0, 32'h0);
        A1 = 5'd1;
        #1;
        total_cnt++; if (RD1 !== 32'h9) $display("FAIL post_rst_x1: got %h expected %h", RD1, 32'h9); else pass_cnt++;
    endtask

    initial begin
        rst = 1'b1;
        ReadDataW = 32'h0;
        PCPlus4W  = 32'h0;
        drive_write(1'b0, 5'd0, 32'h0);
        A1 = 5'd0;
        A2 = 5'd0;
        #2;
        test_reset();
        test_select_mux();
        test_bypass();
        test_x0();
        test_a0_timing();
        test_mid_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
